// File: rtl/conn_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// conn_scheduler_pkg
// Shared definitions for the client/server handshake design.
//   - Parameter defaults for the scheduler.
//   - Server state codes (LISTEN/SYNREC/ESTABLISH/CLOSING), which appear
//     directly on the srv_state output.
//   - Client state codes, so client engines, server and scheduler agree.
// ---------------------------------------------------------------------------
package conn_scheduler_pkg;

    localparam int N_CLIENTS_DEF   = 4;
    localparam int ID_W_DEF        = 2;
    localparam int SYN_TIMEOUT_DEF = 8;
    localparam int HOLD_MAX_DEF    = 16;

    typedef enum logic [2:0] {
        SRV_LISTEN    = 3'b011,
        SRV_SYNREC    = 3'b100,
        SRV_ESTABLISH = 3'b101,
        SRV_CLOSING   = 3'b110
    } srv_state_e;

    typedef enum logic [2:0] {
        CLI_OC          = 3'b000,
        CLI_SYNSENT     = 3'b001,
        CLI_ESTABLISHED = 3'b010
    } cli_state_e;

endpackage

// File: rtl/conn_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector.
//   req   : request vector, one bit per client
//   ptr   : index where the upward scan starts
//   valid : at least one request is set
//   id    : first set request at or above ptr, wrapping modulo N
// ---------------------------------------------------------------------------
module rr_picker
    import conn_scheduler_pkg::*;
#(
    parameter int N    = N_CLIENTS_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        valid = 1'b0;
        id    = ptr;
        idx   = '0;
        // The first hit wins; later hits are masked by valid.
        for (int off = 0; off < N; off++) begin
            idx = ID_W'((int'(ptr) + off) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/conn_scheduler.sv
// ---------------------------------------------------------------------------
// conn_scheduler
// Shares one server handshake engine among N_CLIENTS client engines.
// One client at a time is granted in round-robin order, its 3-way
// handshake is sequenced, and the connection is held until the client
// closes it or the hold limit expires. A stalled SYNREC is aborted.
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   syn_req[N]   : level request per client (client sits in synsent)
//   ack_in[N]    : per-client ack of the SYN-ACK
//   fin_req[N]   : per-client close request
//   grant[N]     : one-hot owner of the server, zero when idle
//   synack_out[N]: one-cycle one-hot SYN-ACK to the granted client
//   established  : high while the connection is in ESTABLISH
//   srv_state    : server state code (also the FSM debug view)
//   active_id    : granted client index, holds its value when idle
//   timeout_err  : one-cycle pulse when a SYNREC attempt times out
//
// Handshake: syn_req is a level request that is only looked at in LISTEN
// (nothing is queued); grant is the acceptance and stays high from the
// SYNREC entry through the CLOSING cycle. Only ack_in/fin_req bits of the
// granted client are observed; all other bits are ignored.
// ---------------------------------------------------------------------------
module conn_scheduler
    import conn_scheduler_pkg::*;
#(
    parameter int N_CLIENTS   = N_CLIENTS_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int SYN_TIMEOUT = SYN_TIMEOUT_DEF,
    parameter int HOLD_MAX    = HOLD_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CLIENTS-1:0] syn_req,
    input  logic [N_CLIENTS-1:0] ack_in,
    input  logic [N_CLIENTS-1:0] fin_req,
    output logic [N_CLIENTS-1:0] grant,
    output logic [N_CLIENTS-1:0] synack_out,
    output logic                 established,
    output logic [2:0]           srv_state,
    output logic [ID_W-1:0]      active_id,
    output logic                 timeout_err
);

    localparam int SYN_W  = (SYN_TIMEOUT > 1) ? $clog2(SYN_TIMEOUT) : 1;
    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [SYN_W-1:0]  SYN_LAST  = SYN_W'(SYN_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [N_CLIENTS-1:0] ONE    = N_CLIENTS'(1);

    srv_state_e           state_q, state_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [N_CLIENTS-1:0] synack_q, synack_d;
    logic                 est_q, est_d;
    logic [ID_W-1:0]      active_id_q, active_id_d;
    logic                 timeout_q, timeout_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SYN_W-1:0]     syn_tmr_q, syn_tmr_d;
    logic [HOLD_W-1:0]    hold_tmr_q, hold_tmr_d;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic [ID_W-1:0]      next_ptr;
    logic                 ack_sel;
    logic                 fin_sel;

    rr_picker #(
        .N    (N_CLIENTS),
        .ID_W (ID_W)
    ) u_rr_picker (
        .req   (syn_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // After a connection ends, the turn passes to the client above it.
    assign next_ptr = (active_id_q == ID_W'(N_CLIENTS - 1)) ? '0
                                                            : active_id_q + ID_W'(1);
    assign ack_sel  = ack_in[active_id_q];
    assign fin_sel  = fin_req[active_id_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        synack_d    = '0;
        est_d       = est_q;
        active_id_d = active_id_q;
        timeout_d   = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        syn_tmr_d   = syn_tmr_q;
        hold_tmr_d  = hold_tmr_q;

        case (state_q)
            SRV_LISTEN: begin
                if (pick_valid) begin
                    state_d     = SRV_SYNREC;
                    grant_d     = ONE << pick_id;
                    synack_d    = ONE << pick_id;
                    active_id_d = pick_id;
                    syn_tmr_d   = '0;
                end
            end
            SRV_SYNREC: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (ack_sel) begin
                    state_d    = SRV_ESTABLISH;
                    est_d      = 1'b1;
                    hold_tmr_d = '0;
                end else if (syn_tmr_q == SYN_LAST) begin
                    state_d   = SRV_LISTEN;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                end else begin
                    syn_tmr_d = syn_tmr_q + SYN_W'(1);
                end
            end
            SRV_ESTABLISH: begin
                if (fin_sel || (hold_tmr_q == HOLD_LAST)) begin
                    state_d = SRV_CLOSING;
                    est_d   = 1'b0;
                end else begin
                    hold_tmr_d = hold_tmr_q + HOLD_W'(1);
                end
            end
            SRV_CLOSING: begin
                state_d  = SRV_LISTEN;
                grant_d  = '0;
                rr_ptr_d = next_ptr;
            end
            default: begin
                state_d = SRV_LISTEN;
                grant_d = '0;
                est_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SRV_LISTEN;
            grant_q     <= '0;
            synack_q    <= '0;
            est_q       <= 1'b0;
            active_id_q <= '0;
            timeout_q   <= 1'b0;
            rr_ptr_q    <= '0;
            syn_tmr_q   <= '0;
            hold_tmr_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            synack_q    <= synack_d;
            est_q       <= est_d;
            active_id_q <= active_id_d;
            timeout_q   <= timeout_d;
            rr_ptr_q    <= rr_ptr_d;
            syn_tmr_q   <= syn_tmr_d;
            hold_tmr_q  <= hold_tmr_d;
        end
    end

    assign grant       = grant_q;
    assign synack_out  = synack_q;
    assign established = est_q;
    assign srv_state   = state_q;
    assign active_id   = active_id_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_conn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conn_scheduler
// Directed bench for conn_scheduler with N_CLIENTS=4, SYN_TIMEOUT=8,
// HOLD_MAX=16. Inputs change 1 time unit after a rising edge and are
// sampled at the next edge; outputs are observed 1 unit after each edge.
// ---------------------------------------------------------------------------
module tb_conn_scheduler;

    localparam int N    = 4;
    localparam int IDW  = 2;

    localparam logic [2:0] ST_LISTEN = 3'b011;
    localparam logic [2:0] ST_SYNREC = 3'b100;
    localparam logic [2:0] ST_EST    = 3'b101;
    localparam logic [2:0] ST_CLOSE  = 3'b110;

    logic           clk     = 1'b0;
    logic           reset   = 1'b1;
    logic [N-1:0]   syn_req = '0;
    logic [N-1:0]   ack_in  = '0;
    logic [N-1:0]   fin_req = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   synack_out;
    logic           established;
    logic [2:0]     srv_state;
    logic [IDW-1:0] active_id;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    logic [IDW-1:0] exp_q[$];

    conn_scheduler #(
        .N_CLIENTS   (N),
        .ID_W        (IDW),
        .SYN_TIMEOUT (8),
        .HOLD_MAX    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .syn_req     (syn_req),
        .ack_in      (ack_in),
        .fin_req     (fin_req),
        .grant       (grant),
        .synack_out  (synack_out),
        .established (established),
        .srv_state   (srv_state),
        .active_id   (active_id),
        .timeout_err (timeout_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance n rising edges, then settle past the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [N-1:0] gr,
                           input logic [N-1:0] sa, input logic est, input logic [IDW-1:0] aid,
                           input logic to);
        chk({tag, "_state"},  32'(srv_state),   32'(st));
        chk({tag, "_grant"},  32'(grant),       32'(gr));
        chk({tag, "_synack"}, 32'(synack_out),  32'(sa));
        chk({tag, "_est"},    32'(established), 32'(est));
        chk({tag, "_id"},     32'(active_id),   32'(aid));
        chk({tag, "_tout"},   32'(timeout_err), 32'(to));
    endtask

    initial begin
        logic           found;
        logic [IDW-1:0] exp_id;

        // Reset
        reset = 1'b1;
        step(3);
        chk_all("reset", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step(1);
        chk_all("idle", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Full handshake with client 2
        syn_req = 4'b0100;
        step(1);
        chk_all("grant2", ST_SYNREC, 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b0);
        syn_req = 4'b0000;
        step(1);
        chk_all("synrec2", ST_SYNREC, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
        ack_in = 4'b0100;
        step(1);
        ack_in = 4'b0000;
        chk_all("est2", ST_EST, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
        step(2);
        chk("est2_hold", 32'(srv_state), 32'(ST_EST));
        fin_req = 4'b0100;
        step(1);
        fin_req = 4'b0000;
        chk_all("close2", ST_CLOSE, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
        step(1);
        chk_all("listen2", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);

        // Timeout on client 1; pointer is 3 so 3,0 are skipped.
        syn_req = 4'b0010;
        step(1);
        syn_req = 4'b0000;
        chk_all("grant1", ST_SYNREC, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
        ack_in = 4'b1000;
        step(1);
        ack_in = 4'b0000;
        chk_all("ack3_ignored", ST_SYNREC, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
        step(6);
        chk_all("synrec1_last", ST_SYNREC, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
        step(1);
        chk_all("timeout1", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1);
        step(1);
        chk("timeout1_pulse", 32'(timeout_err), 32'd0);

        // Pointer is 2: scan 2,3,0 -> client 0.
        syn_req = 4'b0011;
        step(1);
        syn_req = 4'b0000;
        chk_all("grant0_wrap", ST_SYNREC, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
        step(7);
        chk("synrec0_last", 32'(srv_state), 32'(ST_SYNREC));
        ack_in = 4'b0001;
        step(1);
        ack_in = 4'b0000;
        chk_all("ack_vs_timeout", ST_EST, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0);

        // Hold expiry with no fin
        step(15);
        chk("hold_last", 32'(srv_state), 32'(ST_EST));
        step(1);
        chk_all("hold_expire", ST_CLOSE, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        step(1);
        chk_all("hold_listen", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Fin on the same cycle as hold expiry (pointer 1 -> client 1)
        syn_req = 4'b0010;
        step(1);
        syn_req = 4'b0000;
        chk("grant1b", 32'(grant), 32'(4'b0010));
        ack_in = 4'b0010;
        step(1);
        ack_in = 4'b0000;
        chk("est1b", 32'(srv_state), 32'(ST_EST));
        step(15);
        fin_req = 4'b0010;
        step(1);
        fin_req = 4'b0000;
        chk_all("fin_and_expire", ST_CLOSE, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
        step(1);
        chk_all("fin_and_expire_listen", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);
        step(1);
        chk("single_close", 32'(srv_state), 32'(ST_LISTEN));

        // Reset while in ESTABLISH (pointer 2 -> client 3)
        syn_req = 4'b1000;
        step(1);
        syn_req = 4'b0000;
        chk("grant3", 32'(active_id), 32'd3);
        ack_in = 4'b1000;
        step(1);
        ack_in = 4'b0000;
        chk("est3", 32'(established), 32'd1);
        reset = 1'b1;
        step(1);
        chk_all("reset_in_est", ST_LISTEN, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;

        // Round-robin fairness with all clients requesting
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        syn_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 10; w++) begin
                step(1);
                if (synack_out != '0) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rr_wait", 32'(found), 32'd1);
            exp_id = exp_q.pop_front();
            chk("rr_id", 32'(active_id), 32'(exp_id));
            chk("rr_grant", 32'(grant), 32'd1 << exp_id);
            ack_in = grant;
            step(1);
            ack_in = 4'b0000;
            chk("rr_est", 32'(established), 32'd1);
            step(1);
            fin_req = grant;
            step(1);
            fin_req = 4'b0000;
            chk("rr_close", 32'(srv_state), 32'(ST_CLOSE));
        end
        syn_req = 4'b0000;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conn_scheduler.md
Name: conn_scheduler

Overview:
- Shares one server-side handshake engine (LISTEN -> SYNREC -> ESTABLISH) among N client handshake engines.
- Grants one client at a time in round-robin order, sequences that client's 3-way handshake, and holds the connection until the client closes it or a hold limit expires.
- Aborts a stalled handshake on timeout.
- Sits between the client FSM array and the single server FSM in the client/server networking design.

Parameters:
- N_CLIENTS, 4, number of requesting clients (2..8).
- ID_W, 2, width of the client index; must equal ceil(log2(N_CLIENTS)).
- SYN_TIMEOUT, 8, cycles spent in SYNREC without an ack before the attempt is aborted.
- HOLD_MAX, 16, maximum cycles a connection may stay in ESTABLISH before it is force-closed.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- syn_req  in  N_CLIENTS  level request per client: client is in synsent and wants a connection.
- ack_in  in  N_CLIENTS  per-client ack of the SYN-ACK.
- fin_req  in  N_CLIENTS  per-client close request.
- grant  out  N_CLIENTS  one-hot; identifies the client that owns the server; all zero when idle.
- synack_out  out  N_CLIENTS  one-cycle one-hot SYN-ACK pulse to the granted client.
- established  out  1  high while the granted connection is in ESTABLISH.
- srv_state  out  3  server state code: LISTEN=3'b011, SYNREC=3'b100, ESTABLISH=3'b101, CLOSING=3'b110.
- active_id  out  ID_W  index of the granted client; holds its last value when idle.
- timeout_err  out  1  one-cycle pulse when a SYNREC attempt times out.

Behaviour:
- Reset values:
  - srv_state=LISTEN; grant=0; synack_out=0; established=0; active_id=0; timeout_err=0.
  - Round-robin pointer rr_ptr=0; syn timer and hold timer both 0.
- Reset mid-operation: all state returns to reset values on the next edge. No CLOSING cycle and no pulses are emitted.
- All outputs are registered.
- LISTEN:
  - If syn_req != 0 at edge t, select the first set bit scanning upward from rr_ptr, with modulo N_CLIENTS wrap.
  - At t+1: srv_state=SYNREC, grant=onehot(id), active_id=id, synack_out=onehot(id) for exactly that one cycle, syn timer cleared.
  - If no request, stay in LISTEN with all outputs idle.
- SYNREC:
  - The syn timer increments every cycle.
  - If ack_in[active_id]=1, go to ESTABLISH next cycle: established=1, hold timer cleared.
  - Otherwise, when the timer reaches SYN_TIMEOUT-1, go to LISTEN: grant=0, timeout_err pulses for 1 cycle, rr_ptr=active_id+1 mod N.
  - If ack and timeout fall on the same cycle, the ack wins.
  - ack_in from non-granted clients is ignored.
  - Deassertion of syn_req[active_id] in SYNREC is ignored.
- ESTABLISH:
  - The hold timer increments every cycle.
  - fin_req[active_id]=1, or the hold timer reaching HOLD_MAX-1, moves the FSM to CLOSING.
  - Both conditions on the same cycle produce a single transition.
  - established drops in the CLOSING cycle.
- CLOSING:
  - Lasts exactly 1 cycle with grant still asserted.
  - Next cycle: LISTEN, grant=0, rr_ptr=active_id+1 mod N.
- Request handling:
  - syn_req from any client while the FSM is not in LISTEN is not queued. A client whose syn_req stays high is serviced when its round-robin turn comes.
  - Fairness: with all clients continuously requesting, service order is 0,1,2,...,N-1,0.
- Timer widths: enough bits to hold SYN_TIMEOUT-1 and HOLD_MAX-1; timers never wrap.

Decomposition:
- Shared package: the state codes LISTEN/SYNREC/ESTABLISH/CLOSING (plus the client codes oc/synsent/established, so client, server and scheduler agree), and the parameter defaults.
- One sub-module: rr_picker. It is combinational; given req[N] and ptr[ID_W], it returns valid and id.
- FSM, timers and rr_ptr register live in conn_scheduler.

Test Plan:
- Reset, then syn_req=4'b0100 at cycle 2:
  - cycle 3: srv_state=3'b100, grant=4'b0100, synack_out=4'b0100, active_id=2.
  - cycle 4: synack_out=0.
- Full handshake: after the grant above, ack_in[2]=1 at cycle 5 -> established=1 at cycle 6. fin_req[2] at cycle 9 -> srv_state=3'b110 at cycle 10, LISTEN with grant=0 at cycle 11.
- Timeout: grant client 1 with no ack:
  - exactly SYN_TIMEOUT cycles after entering SYNREC, srv_state=LISTEN and timeout_err pulses for 1 cycle.
  - next grant with syn_req=4'b0011 goes to client 0, because the pointer wrapped past 1... from 2 upward.
- Round-robin: syn_req=4'b1111 held; each client acks at once and sends fin 2 cycles later -> grant sequence 0,1,2,3,0.
- Hold expiry: established, no fin -> CLOSING after HOLD_MAX cycles in ESTABLISH. Simultaneous fin and expiry gives a single CLOSING cycle.
- Corner cases:
  - ack_in[3] while client 1 is granted in SYNREC is ignored (stays SYNREC).
  - ack and timeout on the same cycle -> ESTABLISH, no timeout_err.
  - reset asserted in ESTABLISH -> all outputs at reset values on the next edge.
